// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam int STALL_CNT_W = 16;

  // Elaboration-time ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  logic [IDX_W-1:0]   rot_idx [NUM_REQ];
  logic [NUM_REQ-1:0] rot_req;

  // rot_idx[k] is the requester examined k-th when searching from ptr.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [IDX_W:0] sum;
    assign sum        = {1'b0, ptr} + (IDX_W+1)'(gi);
    assign rot_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ?
                         IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : sum[IDX_W-1:0];
    assign rot_req[gi] = req[rot_idx[gi]];
  end

  always_comb begin
    winner  = '0;
    any_req = |rot_req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_req[k]) winner = rot_idx[k];
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NUM_REQ requesters.
// Define FIFO_WRITE_ARBITER_STATS_EN to build the saturating full-stall counter.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      fifo_full,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic [STALL_CNT_W-1:0]    stall_count
);

  localparam int IDX_W  = clog2(NUM_REQ);
  localparam int BEAT_W = clog2(BURST_LEN) + 1;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [IDX_W-1:0]  winner;
  logic              any_req;
  logic              owner_req;
  logic [IDX_W-1:0]  owner_next;
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (req),
    .ptr     (rr_ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  assign owner_req  = req[owner_q];
  assign owner_next = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    grant        = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;

    case (state_q)
      ST_IDLE: begin
        if (any_req && !fifo_full) begin
          owner_d    = winner;
          beat_cnt_d = '0;
          state_d    = ST_BURST;
        end
      end

      ST_BURST: begin
        if (!fifo_full) grant[owner_q] = 1'b1;
        fifo_wr_en = owner_req & !fifo_full;
        if (fifo_wr_en) fifo_wr_data = data_arr[owner_q];

        // A dropped request ends the burst even while the FIFO is full.
        if (!owner_req) begin
          state_d    = ST_IDLE;
          rr_ptr_d   = owner_next;
          beat_cnt_d = '0;
        end else if (fifo_wr_en) begin
          if (beat_cnt_q == BEAT_W'(BURST_LEN - 1)) begin
            state_d    = ST_IDLE;
            rr_ptr_d   = owner_next;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef FIFO_WRITE_ARBITER_STATS_EN
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

  // Counts cycles where the owner has data but the FIFO is full; saturates.
  always_comb begin
    stall_count_d = stall_count_q;
    if ((state_q == ST_BURST) && owner_req && fifo_full && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = '0;
`endif

endmodule
